as_lsu_ctrl: RTL and testbench
==============================

Name: as_lsu_ctrl

Overview:
Load/store sequencing controller between the RV64I core's execute stage and the shared data bus. The data bus serves the data memory and the memory-mapped GPIO window, and the GPIO window drives cs_o.
- Accepts one byte/half/word/double access at a time from the core.
- Generates byte enables and aligned bus addresses.
- Splits accesses that cross an 8-byte boundary into two bus beats.
- Merges and sign/zero-extends read data.
- Flags illegal requests without touching the bus.

Parameters:
XLEN, 64, core data/address width
GPIO_BASE, 64'h0000_0000_0001_0000, first byte address of the GPIO window
GPIO_SIZE, 64'h100, GPIO window size in bytes (power of two)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-low reset
req_i  in  1  core access request
we_i  in  1  1 = store, 0 = load
funct3_i  in  3  RV64I load/store funct3
addr_i  in  XLEN  byte address
wdata_i  in  XLEN  store data, right-aligned
ready_o  out  1  controller can accept a request this cycle
rvalid_o  out  1  one-cycle pulse: access complete
rdata_o  out  XLEN  extended load data, valid with rvalid_o
err_o  out  1  one-cycle pulse: illegal request rejected
bus_req_o  out  1  bus beat request
bus_we_o  out  1  bus write
bus_addr_o  out  XLEN  8-byte-aligned beat address (bits [2:0] = 0)
bus_be_o  out  8  byte enables
bus_wdata_o  out  XLEN  lane-shifted write data
bus_ack_i  in  1  beat complete; bus_rdata_i valid in the same cycle
bus_rdata_i  in  XLEN  beat read data
cs_o  out  1  GPIO chip select, equal to bus_req_o && current beat address in GPIO window

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE.
  - ready_o = 1; all other outputs = 0.
  - Rdata merge buffer cleared.
- Size: funct3[1:0] gives 1/2/4/8 bytes. funct3[2] = 1 means zero-extend (loads only).
- Legal funct3: loads 000–110; stores 000–011.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - ready_o = 1.
  - On req_i with illegal funct3, or any misaligned GPIO access: err_o pulses on the next cycle; no bus beat; stay IDLE.
  - Otherwise latch the request and go to BEAT0.
  - ready_o = 0 in all states other than IDLE.
- BEAT0:
  - bus_addr_o = {addr[XLEN-1:3], 3'b0}.
  - bus_be_o = size mask << addr[2:0], truncated to 8 bits.
  - bus_wdata_o = wdata << (8*addr[2:0]).
  - Hold bus_req_o and all bus fields stable until bus_ack_i.
  - On ack: capture bus_rdata_i. If addr[2:0] + size > 8, go to BEAT1; else go to RESP.
- BEAT1:
  - bus_addr_o = BEAT0 address + 8.
  - bus_be_o = remaining low-lane mask.
  - bus_wdata_o = wdata >> (8*(8 - addr[2:0])).
  - On ack go to RESP.
- bus_req_o drops in the cycle after an ack; there are no back-to-back beats without a one-cycle gap.
- RESP:
  - rvalid_o = 1 for exactly one cycle; rdata_o formed and extended; then IDLE.
  - Stores also pulse rvalid_o; rdata_o = 0 for stores.
- Read merge:
  - Beat-0 bytes are shifted down by addr[2:0].
  - Beat-1 bytes fill from byte (8 - addr[2:0]) upward.
  - Result is masked to size, then sign-extended from its MSB or zero-extended.
- Latency: unaligned-free access with ack on the first bus cycle → rvalid_o 3 cycles after acceptance. A split access adds 2 cycles.
- Address wrap: a BEAT1 address computed modulo 2^XLEN.
- Request held during busy states is ignored; the core must re-present it after ready_o.
- Reset mid-beat: bus_req_o drops immediately; no rvalid_o or err_o is generated for the aborted access.

Decomposition:
- as_pack additions:
  - typedef enum lsu_state_t {IDLE, BEAT0, BEAT1, RESP}.
  - funct3 constants F3_LB..F3_LWU and F3_SB..F3_SD.
  - GPIO_BASE/GPIO_SIZE defaults.
- One sub-module, as_lsu_align (combinational): produces byte-enable masks, write lane shifts, and read merge/extension from size, offset and signedness.
- The FSM stays in as_lsu_ctrl.

Test Plan:
1. LH addr 0x1006, mem dword @0x1000 = 0x8001_2233_4455_6677, ack next cycle → single beat with bus_be_o = 8'hC0; rdata_o = 0xFFFF_FFFF_FFFF_8001; rvalid_o 3 cycles after accept.
2. LHU same address → rdata_o = 0x0000_0000_0000_8001.
3. LW addr 0x100E, dwords @0x1008 = 0x4433_2211_xxxx_xxxx and @0x1010 = 0x0000_0000_0000_6655 → 2 beats with be 8'hC0 then 8'h03; rdata_o = 0x0000_0000_6655_4433.
4. SH wdata 0x0007 to GPIO_BASE+4 → one beat, cs_o = 1, bus_be_o = 8'h30, bus_wdata_o[47:32] = 0x0007; then rvalid_o pulse.
5. LD addr GPIO_BASE+1, and separately store funct3 = 3'b100 → err_o pulses; bus_req_o stays 0; ready_o stays 1.
6. Reset asserted while BEAT0 waits for ack (ack stalled 5 cycles) → bus_req_o = 0 asynchronously; no rvalid_o; after release ready_o = 1 and a new LB completes normally.

Source files
------------

// File: rtl/as_lsu_ctrl_pkg.sv
// Shared types, funct3 encodings and helpers for the load/store controller.
package as_lsu_ctrl_pkg;

  localparam int unsigned LSU_XLEN  = 64;
  localparam int unsigned LSU_LANES = LSU_XLEN / 8;

  localparam logic [63:0] GPIO_BASE_DEF = 64'h0000_0000_0001_0000;
  localparam logic [63:0] GPIO_SIZE_DEF = 64'h100;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Latched core request; size is log2 of the byte count.
  typedef struct packed {
    logic                we;
    logic [1:0]          size;
    logic                uns;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] wdata;
  } lsu_req_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    return we ? (f3 <= F3_SD) : (f3 <= F3_LWU);
  endfunction

  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      2'd2:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/as_lsu_align.sv
// Lane alignment: byte enables, write-data lane shifts and read merge/extension.
module as_lsu_align
  import as_lsu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = LSU_XLEN
) (
  input  logic [1:0]      size,
  input  logic [2:0]      offset,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rbeat0,
  input  logic [XLEN-1:0] rbeat1,
  output logic [7:0]      be0_c,
  output logic [7:0]      be1_c,
  output logic [XLEN-1:0] wdata0_c,
  output logic [XLEN-1:0] wdata1_c,
  output logic [XLEN-1:0] rdata_c,
  output logic            split_c
);

  logic [3:0]        nbytes;
  logic [15:0]       mask_w;
  logic [2*XLEN-1:0] wlane;
  logic [XLEN-1:0]   raw;

  always_comb begin
    nbytes   = 4'(4'd1 << size);
    mask_w   = 16'(((16'd1 << nbytes) - 16'd1) << offset);
    be0_c    = mask_w[7:0];
    be1_c    = mask_w[15:8];
    split_c  = ({1'b0, offset} + nbytes) > 4'd8;
    // Shifting through a double-width word yields both beats' lanes at once.
    wlane    = {{XLEN{1'b0}}, wdata} << {offset, 3'b000};
    wdata0_c = wlane[XLEN-1:0];
    wdata1_c = wlane[2*XLEN-1:XLEN];
    raw      = XLEN'({rbeat1, rbeat0} >> {offset, 3'b000});
    case (size)
      2'd0:    rdata_c = uns ? XLEN'(raw[7:0])  : {{(XLEN-8){raw[7]}},   raw[7:0]};
      2'd1:    rdata_c = uns ? XLEN'(raw[15:0]) : {{(XLEN-16){raw[15]}}, raw[15:0]};
      2'd2:    rdata_c = uns ? XLEN'(raw[31:0]) : {{(XLEN-32){raw[31]}}, raw[31:0]};
      default: rdata_c = raw;
    endcase
  end

endmodule

// File: rtl/as_lsu_ctrl.sv
// Load/store sequencer: one core access at a time, split into at most two aligned bus beats.
module as_lsu_ctrl
  import as_lsu_ctrl_pkg::*;
#(
  parameter int unsigned      XLEN      = LSU_XLEN,
  parameter logic [XLEN-1:0]  GPIO_BASE = XLEN'(GPIO_BASE_DEF),
  parameter logic [XLEN-1:0]  GPIO_SIZE = XLEN'(GPIO_SIZE_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            ready_o,
  output logic            rvalid_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [7:0]      bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_ack_i,
  input  logic [XLEN-1:0] bus_rdata_i,
  output logic            cs_o
);

  localparam logic [XLEN-1:0] BEAT_STRIDE = XLEN'(8);

  lsu_state_t      state_q, state_d;
  lsu_req_t        req_q, req_d, in_req, cur_req;
  logic [XLEN-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [XLEN-1:0] beat0_addr;

  logic            ready_d, rvalid_d, err_d, cs_d;
  logic [XLEN-1:0] rdata_d;
  logic            bus_req_d, bus_we_d;
  logic [XLEN-1:0] bus_addr_d, bus_wdata_d;
  logic [7:0]      bus_be_d;

  logic [7:0]      be0, be1;
  logic [XLEN-1:0] wdata0, wdata1, merged;
  logic            split;

  function automatic logic in_gpio(input logic [XLEN-1:0] a);
    return (a & ~(GPIO_SIZE - XLEN'(1))) == GPIO_BASE;
  endfunction

  // In IDLE the aligner looks at the incoming request so beat 0 can launch on acceptance.
  always_comb begin
    in_req.we    = we_i;
    in_req.size  = funct3_i[1:0];
    in_req.uns   = funct3_i[2];
    in_req.addr  = addr_i;
    in_req.wdata = wdata_i;
    cur_req      = (state_q == IDLE) ? in_req : req_q;
    beat0_addr   = {cur_req.addr[XLEN-1:3], 3'b000};
  end

  as_lsu_align #(.XLEN(XLEN)) u_align (
    .size     (cur_req.size),
    .offset   (cur_req.addr[2:0]),
    .uns      (cur_req.uns),
    .wdata    (cur_req.wdata),
    .rbeat0   (buf0_q),
    .rbeat1   (buf1_q),
    .be0_c    (be0),
    .be1_c    (be1),
    .wdata0_c (wdata0),
    .wdata1_c (wdata1),
    .rdata_c  (merged),
    .split_c  (split)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    ready_d     = 1'b0;
    rvalid_d    = 1'b0;
    rdata_d     = '0;
    err_d       = 1'b0;
    bus_req_d   = bus_req_o;
    bus_we_d    = bus_we_o;
    bus_addr_d  = bus_addr_o;
    bus_be_d    = bus_be_o;
    bus_wdata_d = bus_wdata_o;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_i) begin
          if (!f3_legal(we_i, funct3_i) ||
              (in_gpio(addr_i) && misaligned(addr_i[2:0], funct3_i[1:0]))) begin
            err_d = 1'b1;
          end else begin
            req_d       = in_req;
            state_d     = BEAT0;
            ready_d     = 1'b0;
            bus_req_d   = 1'b1;
            bus_we_d    = we_i;
            bus_addr_d  = beat0_addr;
            bus_be_d    = be0;
            bus_wdata_d = wdata0;
          end
        end
      end
      BEAT0: begin
        if (bus_ack_i) begin
          buf0_d      = bus_rdata_i;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_be_d    = '0;
          bus_wdata_d = '0;
          state_d     = split ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        // First BEAT1 cycle is the mandatory idle gap on the bus.
        if (!bus_req_o) begin
          bus_req_d   = 1'b1;
          bus_we_d    = req_q.we;
          bus_addr_d  = beat0_addr + BEAT_STRIDE;
          bus_be_d    = be1;
          bus_wdata_d = wdata1;
        end else if (bus_ack_i) begin
          buf1_d      = bus_rdata_i;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_be_d    = '0;
          bus_wdata_d = '0;
          state_d     = RESP;
        end
      end
      RESP: begin
        rvalid_d = 1'b1;
        rdata_d  = req_q.we ? '0 : merged;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cs_d = bus_req_d && in_gpio(bus_addr_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      req_q       <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      ready_o     <= 1'b1;
      rvalid_o    <= 1'b0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      cs_o        <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      ready_o     <= ready_d;
      rvalid_o    <= rvalid_d;
      rdata_o     <= rdata_d;
      err_o       <= err_d;
      bus_req_o   <= bus_req_d;
      bus_we_o    <= bus_we_d;
      bus_addr_o  <= bus_addr_d;
      bus_be_o    <= bus_be_d;
      bus_wdata_o <= bus_wdata_d;
      cs_o        <= cs_d;
    end
  end

endmodule

// File: tb/tb_as_lsu_ctrl.sv
// Scoreboard bench for as_lsu_ctrl: byte-level memory model, bus slave and response monitor.
module tb_as_lsu_ctrl;
  import as_lsu_ctrl_pkg::*;

  localparam logic [63:0] GBASE = 64'h0000_0000_0001_0000;
  localparam logic [63:0] GSIZE = 64'h100;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  funct3_i = 3'b0;
  logic [63:0] addr_i = '0;
  logic [63:0] wdata_i = '0;
  logic        ready_o, rvalid_o, err_o;
  logic [63:0] rdata_o;
  logic        bus_req_o, bus_we_o, cs_o;
  logic [63:0] bus_addr_o, bus_wdata_o;
  logic [7:0]  bus_be_o;
  logic        bus_ack_i = 1'b0;
  logic [63:0] bus_rdata_i = '0;

  as_lsu_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .cs_o(cs_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  be;
    logic        we;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    bit          is_err;
    logic [63:0] rdata;
  } resp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_delay = 0;
  int          wcnt = 0;
  beat_t       exp_beats[$];
  resp_t       exp_resp[$];
  logic [7:0]  beat_log[$];
  logic [63:0] wdata_log[$];
  logic        cs_log[$];
  logic [63:0] last_rdata = '0;
  logic [7:0]  ref_mem [logic [63:0]];
  logic [63:0] bus_mem [logic [63:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_dword(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [63:0] a);
    logic [63:0] d;
    if (ref_mem.exists(a)) return ref_mem[a];
    d = init_dword(a & ~64'h7);
    return d[8*a[2:0] +: 8];
  endfunction

  function automatic logic is_gpio(input logic [63:0] a);
    return (a >= GBASE) && (a < GBASE + GSIZE);
  endfunction

  task automatic preload(input logic [63:0] a, input logic [63:0] d);
    bus_mem[a] = d;
    for (int i = 0; i < 8; i++) ref_mem[a + 64'(i)] = d[8*i +: 8];
  endtask

  // Model the access from byte-level rules, queue expectations, then present the request.
  task automatic send(input logic we, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd);
    int          n, w;
    logic        legal;
    logic [63:0] d0, ba, val;
    beat_t       b0, b1;
    resp_t       r;
    n     = 1 << f3[1:0];
    legal = we ? (f3[2] == 1'b0) : (f3 != 3'b111);
    r.is_err = 1'b0;
    r.rdata  = '0;
    if (!legal || (is_gpio(a) && (a % 64'(n)) != 0)) begin
      r.is_err = 1'b1;
    end else begin
      d0 = a & ~64'h7;
      b0.addr = d0;          b0.be = '0; b0.we = we; b0.wdata = '0;
      b1.addr = d0 + 64'd8;  b1.be = '0; b1.we = we; b1.wdata = '0;
      val = '0;
      for (int i = 0; i < n; i++) begin
        ba = a + 64'(i);
        if ((ba & ~64'h7) == d0) begin
          b0.be[ba[2:0]] = 1'b1;
          b0.wdata[8*ba[2:0] +: 8] = wd[8*i +: 8];
        end else begin
          b1.be[ba[2:0]] = 1'b1;
          b1.wdata[8*ba[2:0] +: 8] = wd[8*i +: 8];
        end
        if (we) ref_mem[ba] = wd[8*i +: 8];
        else    val[8*i +: 8] = ref_byte(ba);
      end
      if (!we && !f3[2] && val[8*n-1]) val = val | ~((64'd1 << (8*n)) - 64'd1);
      r.rdata = we ? 64'd0 : val;
      exp_beats.push_back(b0);
      if (b1.be != 8'h00) exp_beats.push_back(b1);
    end
    exp_resp.push_back(r);

    @(negedge clk_i);
    w = 0;
    while (!ready_o && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    check("ready_at_issue", 64'(ready_o), 64'd1);
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
    @(negedge clk_i);
    req_i = 1'b0;
  endtask

  // Cycles from acceptance edge to the negedge where rvalid_o/err_o is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!(rvalid_o || err_o) && lat < 60) begin
      @(negedge clk_i);
      lat++;
    end
    check("done_in_bound", 64'(rvalid_o | err_o), 64'd1);
    #1;
  endtask

  // Bus slave: acks after ack_delay waiting cycles and checks each beat against the queue.
  always @(negedge clk_i) begin
    logic [63:0] d;
    beat_t       e;
    logic [63:0] lm;
    if (!rst_i) begin
      bus_ack_i = 1'b0;
      wcnt = 0;
    end else if (bus_ack_i) begin
      bus_ack_i = 1'b0;
    end else if (bus_req_o) begin
      if (wcnt < ack_delay) begin
        wcnt++;
      end else begin
        wcnt = 0;
        d = bus_mem.exists(bus_addr_o) ? bus_mem[bus_addr_o] : init_dword(bus_addr_o);
        bus_rdata_i = d;
        lm = '0;
        for (int l = 0; l < 8; l++) if (bus_be_o[l]) lm[8*l +: 8] = 8'hFF;
        if (bus_we_o) begin
          d = (d & ~lm) | (bus_wdata_o & lm);
          bus_mem[bus_addr_o] = d;
        end
        beat_log.push_back(bus_be_o);
        wdata_log.push_back(bus_wdata_o);
        cs_log.push_back(cs_o);
        check("beat_expected", 64'(exp_beats.size() != 0), 64'd1);
        if (exp_beats.size() != 0) begin
          e = exp_beats.pop_front();
          check("beat_addr", bus_addr_o, e.addr);
          check("beat_be", 64'(bus_be_o), 64'(e.be));
          check("beat_we", 64'(bus_we_o), 64'(e.we));
          check("beat_cs", 64'(cs_o), 64'(is_gpio(e.addr)));
          if (e.we) check("beat_wdata", bus_wdata_o & lm, e.wdata);
        end
        bus_ack_i = 1'b1;
      end
    end
  end

  // Response monitor.
  always @(negedge clk_i) begin
    resp_t e;
    if (rst_i && (rvalid_o || err_o)) begin
      check("resp_expected", 64'(exp_resp.size() != 0), 64'd1);
      if (exp_resp.size() != 0) begin
        e = exp_resp.pop_front();
        check("resp_err", 64'(err_o), 64'(e.is_err));
        check("resp_rvalid", 64'(rvalid_o), 64'(!e.is_err));
        if (!e.is_err) check("resp_rdata", rdata_o, e.rdata);
      end
      last_rdata = rdata_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int r;
    logic [63:0] a;

    // Reset values.
    #12;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_bus_req", 64'(bus_req_o), 64'd0);
    check("rst_cs", 64'(cs_o), 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // LH / LHU single beat.
    preload(64'h1000, 64'h8001_2233_4455_6677);
    ack_delay = 0;
    beat_log.delete();
    send(1'b0, F3_LH, 64'h1006, 64'd0);
    wait_done(lat);
    check("t1_latency", 64'(lat), 64'd3);
    check("t1_beats", 64'(beat_log.size()), 64'd1);
    check("t1_be", 64'(beat_log[0]), 64'hC0);
    check("t1_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_8001);
    send(1'b0, F3_LHU, 64'h1006, 64'd0);
    wait_done(lat);
    check("t2_latency", 64'(lat), 64'd3);
    check("t2_rdata", last_rdata, 64'h0000_0000_0000_8001);

    // LW split across two dwords.
    preload(64'h1008, 64'h4433_2211_DEAD_BEEF);
    preload(64'h1010, 64'h0000_0000_0000_6655);
    beat_log.delete();
    send(1'b0, F3_LW, 64'h100E, 64'd0);
    wait_done(lat);
    check("t3_latency", 64'(lat), 64'd5);
    check("t3_beats", 64'(beat_log.size()), 64'd2);
    check("t3_be0", 64'(beat_log[0]), 64'hC0);
    check("t3_be1", 64'(beat_log[1]), 64'h03);
    check("t3_rdata", last_rdata, 64'h0000_0000_6655_4433);

    // SH into the GPIO window.
    beat_log.delete(); wdata_log.delete(); cs_log.delete();
    send(1'b1, F3_SH, GBASE + 64'd4, 64'h0007);
    wait_done(lat);
    check("t4_beats", 64'(beat_log.size()), 64'd1);
    check("t4_be", 64'(beat_log[0]), 64'h30);
    check("t4_cs", 64'(cs_log[0]), 64'd1);
    check("t4_wdata_lane", 64'(wdata_log[0][47:32]), 64'h0007);
    check("t4_rdata", last_rdata, 64'd0);

    // Illegal requests rejected without bus traffic.
    beat_log.delete();
    send(1'b0, F3_LD, GBASE + 64'd1, 64'd0);
    wait_done(lat);
    check("t5_ld_err_latency", 64'(lat), 64'd1);
    check("t5_ld_ready", 64'(ready_o), 64'd1);
    send(1'b1, 3'b100, 64'h1000, 64'h55);
    wait_done(lat);
    check("t5_st_err_latency", 64'(lat), 64'd1);
    check("t5_st_ready", 64'(ready_o), 64'd1);
    check("t5_no_beats", 64'(beat_log.size()), 64'd0);

    // Reset while beat 0 is stalled.
    ack_delay = 1000;
    send(1'b0, F3_LB, 64'h1003, 64'd0);
    repeat (3) @(negedge clk_i);
    check("t6_busreq_stalled", 64'(bus_req_o), 64'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("t6_busreq_async_drop", 64'(bus_req_o), 64'd0);
    check("t6_ready_in_reset", 64'(ready_o), 64'd1);
    exp_beats.delete();
    exp_resp.delete();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    ack_delay = 0;
    repeat (3) @(negedge clk_i);
    check("t6_ready_after", 64'(ready_o), 64'd1);
    check("t6_no_rvalid", 64'(rvalid_o), 64'd0);
    send(1'b0, F3_LB, 64'h1003, 64'd0);
    wait_done(lat);
    check("t6_lb_latency", 64'(lat), 64'd3);

    // Randomized traffic over data memory, GPIO window and the top of the address space.
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      a = 64'h1000 + 64'($urandom_range(0, 255));
      else if (r <= 8) a = GBASE + 64'($urandom_range(0, 255));
      else             a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      ack_delay = $urandom_range(0, 2);
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
           {32'($urandom), 32'($urandom)});
      wait_done(lat);
    end

    repeat (4) @(negedge clk_i);
    check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
    check("beat_queue_drained", 64'(exp_beats.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
